// File: rtl/int_sequencer.sv
// Interrupt/BRK sequencer: arbitrates reset, NCH request channels and BRK at
// instruction boundaries, then steps through the vector-fetch sequence.
module int_sequencer #(
  parameter int               NCH       = 2,
  parameter logic [NCH-1:0]   EDGE_MASK = NCH'(1),
  parameter logic [NCH-1:0]   NMI_MASK  = NCH'(1),
  parameter int               SEQ_LEN   = 7,
  parameter logic [15:0]      VEC_TOP   = 16'hFFFE
) (
  input  logic                         PHI0,
  input  logic                         n_RES,
  input  logic                         RESP,
  input  logic                         n_ready,
  input  logic                         T0,
  input  logic                         BRK_OP,
  input  logic                         I_FLAG,
  input  logic [NCH-1:0]               n_IRQ,
  output logic                         SEQ_ACTIVE,
  output logic [$clog2(SEQ_LEN)-1:0]   SEQ_STEP,
  output logic [15:0]                  VEC_ADDR,
  output logic                         VEC_LO,
  output logic                         VEC_HI,
  output logic                         B_OUT,
  output logic                         DORES,
  output logic [NCH-1:0]               ACK
);

  localparam int SW = $clog2(SEQ_LEN);
  localparam int CW = $clog2(NCH + 2);
  localparam logic [SW-1:0] C_STEP    = SW'(SEQ_LEN - 3);
  localparam logic [SW-1:0] LO_STEP   = SW'(SEQ_LEN - 2);
  localparam logic [SW-1:0] LAST_STEP = SW'(SEQ_LEN - 1);
  localparam logic [CW-1:0] CODE_BRK  = '0;
  localparam logic [CW-1:0] CODE_RES  = CW'(1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state_reg, state_next;
  logic [SW-1:0]   step_reg, step_next;
  logic [CW-1:0]   code_reg, code_next;
  logic            reset_req_reg, reset_req_next;
  logic            por_reg, por_next;
  logic [15:0]     vec_reg;
  logic [NCH-1:0]  samp_reg;
  logic [NCH-1:0]  pending, eligible, ack;
  logic            commit;
  logic            elig_any;
  logic [CW-1:0]   elig_code;

  // RESP overrides the commit step so a restarted sequence acknowledges nothing
  assign commit = (state_reg == S_RUN) && (step_reg == C_STEP) && !n_ready && !RESP;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    if (EDGE_MASK[gi]) begin : g_edge
      logic lat_reg;
      always_ff @(posedge PHI0 or negedge n_RES) begin
        if (!n_RES)
          lat_reg <= 1'b0;
        else
          lat_reg <= (samp_reg[gi] & ~n_IRQ[gi]) | (lat_reg & ~ack[gi]);
      end
      assign pending[gi] = lat_reg;
    end else begin : g_level
      assign pending[gi] = ~samp_reg[gi];
    end
    assign eligible[gi] = pending[gi] & (NMI_MASK[gi] | ~I_FLAG);
    assign ack[gi]      = commit && (code_reg == CW'(gi + 2));
  end

  always_comb begin
    elig_any  = 1'b0;
    elig_code = CODE_BRK;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        elig_any  = 1'b1;
        elig_code = CW'(k + 2);
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    step_next      = step_reg;
    code_next      = code_reg;
    por_next       = por_reg;
    reset_req_next = RESP | (reset_req_reg & ~(commit && code_reg == CODE_RES));
    case (state_reg)
      S_IDLE: begin
        if (!n_ready) begin
          if (reset_req_reg) begin
            state_next = S_RUN;
            step_next  = '0;
            code_next  = CODE_RES;
          end else if (T0 && elig_any) begin
            state_next = S_RUN;
            step_next  = '0;
            code_next  = elig_code;
          end else if (T0 && BRK_OP) begin
            state_next = S_RUN;
            step_next  = '0;
            code_next  = CODE_BRK;
          end
        end
      end
      S_RUN: begin
        if (RESP) begin
          step_next = '0;
          code_next = CODE_RES;
        end else if (!n_ready) begin
          if (step_reg == LAST_STEP) begin
            state_next = S_IDLE;
            step_next  = '0;
            if (code_reg == CODE_RES)
              por_next = 1'b0;
          end else begin
            step_next = step_reg + SW'(1);
            // Late arrival: a better channel may take over until the commit step
            if (step_reg < C_STEP && code_reg != CODE_RES && elig_any &&
                (code_reg == CODE_BRK || elig_code < code_reg))
              code_next = elig_code;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge PHI0 or negedge n_RES) begin
    if (!n_RES) begin
      state_reg     <= S_IDLE;
      step_reg      <= '0;
      code_reg      <= CODE_RES;
      reset_req_reg <= 1'b1;
      por_reg       <= 1'b1;
      vec_reg       <= VEC_TOP - 16'd2;
      samp_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      step_reg      <= step_next;
      code_reg      <= code_next;
      reset_req_reg <= reset_req_next;
      por_reg       <= por_next;
      vec_reg       <= VEC_TOP - 16'({code_next, 1'b0});
      samp_reg      <= n_IRQ;
    end
  end

  assign SEQ_ACTIVE = (state_reg == S_RUN);
  assign SEQ_STEP   = step_reg;
  assign VEC_ADDR   = vec_reg;
  assign VEC_LO     = SEQ_ACTIVE && (step_reg == LO_STEP);
  assign VEC_HI     = SEQ_ACTIVE && (step_reg == LAST_STEP);
  assign B_OUT      = SEQ_ACTIVE && (code_reg == CODE_BRK);
  assign DORES      = por_reg || (SEQ_ACTIVE && code_reg == CODE_RES);
  assign ACK        = ack;

endmodule
